// File: rtl/iob_eth_defs.sv
// Shared definitions for the Ethernet RX/TX buffer control path.
package iob_eth_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } rx_state_t;

  localparam int DEF_BUF_AW = 11;

endpackage

// File: rtl/iob_eth_tgl_sync.sv
// Toggle-to-pulse crossing: 2-flop synchronizer plus edge detect.
// Each level change of tgl produces one single-cycle pulse in the clk domain.
module iob_eth_tgl_sync (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  output logic pulse
);

  logic [2:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], tgl};
  end

  assign pulse = sync[2] ^ sync[1];

endmodule

// File: rtl/iob_eth_rx_buf_ctrl.sv
// RX frame ring controller: allocates a slot per frame, generates RAM write
// addresses, commits/discards on the CRC verdict, frees slots on host release.
module iob_eth_rx_buf_ctrl
  import iob_eth_defs::*;
#(
  parameter int NBUF   = 4,
  parameter int BUF_AW = DEF_BUF_AW,
  parameter int CNT_W  = 8,
  localparam int IW    = $clog2(NBUF)
) (
  input  logic                 RX_CLK,
  input  logic                 rst,
  input  logic                 rx_start,
  input  logic                 rx_wr,
  input  logic                 rx_end_ok,
  input  logic                 rx_end_bad,
  input  logic                 ack_tgl,
  output logic [IW+BUF_AW-1:0] wbuf_addr,
  output logic                 wbuf_we,
  output logic [IW-1:0]        rd_idx,
  output logic [BUF_AW-1:0]    rd_len,
  output logic [IW:0]          frame_cnt,
  output logic                 frames_avail,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     bad_cnt
);

  rx_state_t         state, nxt;
  logic [IW-1:0]     wr_idx;
  logic [BUF_AW-1:0] byte_cnt;
  logic [BUF_AW-1:0] len [NBUF];
  logic              rel_pulse, release_ok;
  logic              slot_free, ovf, empty;
  logic              commit, bad_ev, drop_ev, clr_cnt;

  iob_eth_tgl_sync u_ack_sync (
    .clk   (RX_CLK),
    .rst   (rst),
    .tgl   (ack_tgl),
    .pulse (rel_pulse)
  );

  assign wbuf_we      = rx_wr && (state == ST_RECV);
  assign wbuf_addr    = {wr_idx, byte_cnt};
  assign rd_len       = len[rd_idx];
  assign frames_avail = (frame_cnt != '0);

  // A release in the same cycle as a start does not make room for it yet.
  assign slot_free  = (frame_cnt != (IW+1)'(NBUF));
  assign ovf        = rx_wr && (&byte_cnt);
  assign empty      = (byte_cnt == '0) && !rx_wr;
  assign release_ok = rel_pulse && frames_avail;

  always_comb begin
    nxt     = state;
    commit  = 1'b0;
    bad_ev  = 1'b0;
    drop_ev = 1'b0;
    clr_cnt = 1'b0;
    unique case (state)
      ST_IDLE:
        if (rx_start) begin
          if (slot_free) begin nxt = ST_RECV; clr_cnt = 1'b1; end
          else           begin nxt = ST_DROP; drop_ev = 1'b1; end
        end
      ST_RECV:
        if (rx_end_bad) begin
          nxt = ST_IDLE; bad_ev = 1'b1;
        end else if (rx_end_ok) begin
          nxt = ST_IDLE;
          if (empty || ovf) bad_ev = 1'b1;
          else              commit = 1'b1;
        end else if (rx_start) begin
          bad_ev = 1'b1; clr_cnt = 1'b1;
        end else if (ovf) begin
          nxt = ST_DROP; bad_ev = 1'b1;
        end
      ST_DROP:
        if (rx_end_ok || rx_end_bad) begin
          nxt = ST_IDLE;
        end else if (rx_start) begin
          if (slot_free) begin nxt = ST_RECV; clr_cnt = 1'b1; end
          else           drop_ev = 1'b1;
        end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_idx   <= '0;
      byte_cnt <= '0;
      bad_cnt  <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < NBUF; i++) len[i] <= '0;
    end else begin
      state <= nxt;
      if (clr_cnt)      byte_cnt <= '0;
      else if (wbuf_we) byte_cnt <= byte_cnt + BUF_AW'(1);
      if (commit) begin
        len[wr_idx] <= byte_cnt + BUF_AW'(rx_wr);
        wr_idx      <= wr_idx + IW'(1);
      end
      if (bad_ev && !(&bad_cnt))   bad_cnt  <= bad_cnt + CNT_W'(1);
      if (drop_ev && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      rd_idx    <= '0;
      frame_cnt <= '0;
    end else begin
      if (release_ok) rd_idx <= rd_idx + IW'(1);
      unique case ({commit, release_ok})
        2'b10:   frame_cnt <= frame_cnt + (IW+1)'(1);
        2'b01:   frame_cnt <= frame_cnt - (IW+1)'(1);
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_eth_rx_buf_ctrl.sv
// Scoreboard bench for iob_eth_rx_buf_ctrl: per-cycle expectations from a
// queue-based frame model, compared by an independent negedge monitor.
module tb_iob_eth_rx_buf_ctrl;

  localparam int NBUF   = 4;
  localparam int BUF_AW = 7;
  localparam int CNT_W  = 3;
  localparam int IW     = 2;
  localparam int MAXB   = (1 << BUF_AW) - 1;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic                 RX_CLK = 1'b0;
  logic                 rst = 1'b1;
  logic                 rx_start = 1'b0, rx_wr = 1'b0, rx_end_ok = 1'b0, rx_end_bad = 1'b0;
  logic                 ack_tgl = 1'b0;
  logic [IW+BUF_AW-1:0] wbuf_addr;
  logic                 wbuf_we;
  logic [IW-1:0]        rd_idx;
  logic [BUF_AW-1:0]    rd_len;
  logic [IW:0]          frame_cnt;
  logic                 frames_avail;
  logic [CNT_W-1:0]     drop_cnt, bad_cnt;

  iob_eth_rx_buf_ctrl #(.NBUF(NBUF), .BUF_AW(BUF_AW), .CNT_W(CNT_W)) dut (
    .RX_CLK(RX_CLK), .rst(rst), .rx_start(rx_start), .rx_wr(rx_wr),
    .rx_end_ok(rx_end_ok), .rx_end_bad(rx_end_bad), .ack_tgl(ack_tgl),
    .wbuf_addr(wbuf_addr), .wbuf_we(wbuf_we), .rd_idx(rd_idx), .rd_len(rd_len),
    .frame_cnt(frame_cnt), .frames_avail(frames_avail),
    .drop_cnt(drop_cnt), .bad_cnt(bad_cnt)
  );

  always #5 RX_CLK = ~RX_CLK;

  typedef struct {
    bit we;
    int addr;
    int fc;
    int rdi;
    int rdl;   // -1 when no frame is available
    int drop;
    int bad;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, passes = 0;

  // Reference model: committed frame lengths in arrival order plus ring slots.
  int lens[$];
  int rel_due[$];
  int wr_slot = 0, rd_slot = 0, mode = 0, cnt = 0, drop = 0, bad = 0, stepn = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  always @(negedge RX_CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      bit ok;
      e = sb.pop_front();
      ok = (wbuf_we === e.we) && (!e.we || int'(wbuf_addr) == e.addr) &&
           (int'(frame_cnt) == e.fc) && (frames_avail === (e.fc != 0)) &&
           (int'(rd_idx) == e.rdi) && (e.rdl < 0 || int'(rd_len) == e.rdl) &&
           (int'(drop_cnt) == e.drop) && (int'(bad_cnt) == e.bad);
      checks++;
      if (ok) passes++;
      else $display("FAIL sb t=%0t actual we=%0b addr=%0h fc=%0d rdi=%0d rdl=%0d drop=%0d bad=%0d required we=%0b addr=%0h fc=%0d rdi=%0d rdl=%0d drop=%0d bad=%0d",
                    $time, wbuf_we, wbuf_addr, frame_cnt, rd_idx, rd_len, drop_cnt, bad_cnt,
                    e.we, e.addr, e.fc, e.rdi, e.rdl, e.drop, e.bad);
    end else if (!rst && wbuf_we === 1'b1) begin
      checks++;
      $display("FAIL unexpected_we actual=1 required=0 addr=%0h", wbuf_addr);
    end
  end

  // One clock of stimulus: drive pulses, record expectation, advance the model.
  task automatic step(input bit st, input bit wr, input bit ok, input bit bd, input bit tg);
    exp_t e;
    bit full, rel, ovf, commit;
    int n;
    @(posedge RX_CLK); #1;
    rx_start = st; rx_wr = wr; rx_end_ok = ok; rx_end_bad = bd;
    if (tg) begin
      ack_tgl = ~ack_tgl;
      rel_due.push_back(stepn + 2);
    end
    e.we   = wr && mode == 1;
    e.addr = wr_slot * (MAXB + 1) + cnt;
    e.fc   = lens.size();
    e.rdi  = rd_slot;
    e.rdl  = (lens.size() > 0) ? lens[0] : -1;
    e.drop = drop;
    e.bad  = bad;
    sb.push_back(e);

    full = lens.size() == NBUF;
    rel = 0;
    if (rel_due.size() > 0 && rel_due[0] == stepn) begin
      void'(rel_due.pop_front());
      rel = 1;
    end
    commit = 0;
    n = cnt + int'(wr);
    ovf = wr && cnt == MAXB;
    case (mode)
      0: if (st) begin
           if (full) begin mode = 2; if (drop < SAT) drop++; end
           else begin mode = 1; cnt = 0; end
         end
      1: if (bd) begin
           mode = 0; if (bad < SAT) bad++;
         end else if (ok) begin
           mode = 0;
           if (n == 0 || ovf) begin if (bad < SAT) bad++; end
           else commit = 1;
         end else if (st) begin
           cnt = 0; if (bad < SAT) bad++;
         end else if (wr) begin
           if (ovf) begin mode = 2; if (bad < SAT) bad++; end
           else cnt++;
         end
      default: if (ok || bd) mode = 0;
               else if (st) begin
                 if (!full) begin mode = 1; cnt = 0; end
                 else if (drop < SAT) drop++;
               end
    endcase
    if (rel && lens.size() > 0) begin
      void'(lens.pop_front());
      rd_slot = (rd_slot + 1) % NBUF;
    end
    if (commit) begin
      lens.push_back(n);
      wr_slot = (wr_slot + 1) % NBUF;
    end
    stepn++;
  endtask

  task automatic idle(input int k);
    repeat (k) step(0, 0, 0, 0, 0);
  endtask

  task automatic frame(input int nb, input bit good);
    step(1, 0, 0, 0, 0);
    repeat (nb) step(0, 1, 0, 0, 0);
    step(0, 0, good, !good, 0);
  endtask

  task automatic drain();
    idle(4);
    while (lens.size() > 0) begin
      step(0, 0, 0, 0, 1);
      idle(3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge RX_CLK);
    #2;
    chk("rst_we", int'(wbuf_we), 0);
    chk("rst_fc", int'(frame_cnt), 0);
    chk("rst_avail", int'(frames_avail), 0);
    chk("rst_rdlen", int'(rd_len), 0);
    chk("rst_rdidx", int'(rd_idx), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_bad", int'(bad_cnt), 0);
    rst = 1'b0;

    // Good frame, then fill the ring and drop a fifth frame.
    frame(64, 1);
    idle(2);
    repeat (3) frame(60, 1);
    frame(60, 1);
    idle(1);
    step(0, 0, 0, 0, 1);
    idle(3);
    frame(60, 1);             // lands in slot 0 again
    // Full ring: release and start in the same cycle still drops.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    drain();

    // Bad CRC, then the same slot is reused; zero-byte good frame is bad.
    frame(100, 0);
    frame(30, 1);
    frame(0, 1);
    // Overflow: 132 writes into a 128-byte slot, then end_ok commits nothing.
    frame(132, 1);
    // Resync: start while receiving restarts the same slot.
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    drain();

    // Write together with end_ok: 9 + 1 bytes.
    step(1, 0, 0, 0, 0);
    repeat (9) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    idle(2);
    // Commit and release in the same cycle with two frames pending.
    frame(12, 1);
    step(1, 0, 0, 0, 0);
    repeat (7) step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (7) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    idle(4);
    drain();

    // Counter saturation.
    repeat (10) begin step(1, 0, 0, 0, 0); step(0, 0, 0, 1, 0); end
    repeat (4) frame(5, 1);
    repeat (10) begin step(1, 0, 0, 0, 0); step(0, 0, 1, 0, 0); end
    drain();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit tg;
      r  = $urandom_range(0, 99);
      tg = ($urandom_range(0, 19) == 0);
      if (r < 5)       step(1, 0, 0, 0, tg);
      else if (r < 75) step(0, 1, 0, 0, tg);
      else if (r < 79) step(0, 0, 1, 0, tg);
      else if (r < 81) step(0, 1, 1, 0, tg);
      else if (r < 84) step(0, 0, 0, 1, tg);
      else if (r < 85) step(0, 0, 1, 1, tg);
      else             step(0, 0, 0, 0, tg);
    end
    step(0, 0, 0, 1, 0);
    drain();

    // Async reset in the middle of a frame with three frames committed.
    repeat (3) frame(10, 1);
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    @(posedge RX_CLK); #1;
    chk("pre_rst_fc", int'(frame_cnt), 3);
    rx_wr = 1'b1; ack_tgl = 1'b0; rst = 1'b1;
    #1;
    chk("arst_we", int'(wbuf_we), 0);
    chk("arst_fc", int'(frame_cnt), 0);
    chk("arst_avail", int'(frames_avail), 0);
    chk("arst_rdlen", int'(rd_len), 0);
    chk("arst_rdidx", int'(rd_idx), 0);
    chk("arst_addr", int'(wbuf_addr), 0);
    chk("arst_bad", int'(bad_cnt), 0);
    rx_wr = 1'b0;
    repeat (2) @(posedge RX_CLK);
    #2 rst = 1'b0;
    lens.delete(); rel_due.delete();
    wr_slot = 0; rd_slot = 0; mode = 0; cnt = 0; drop = 0; bad = 0;
    frame(20, 1);
    idle(3);

    @(posedge RX_CLK); #1;
    rx_start = 0; rx_wr = 0; rx_end_ok = 0; rx_end_bad = 0;
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge RX_CLK);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/iob_eth_rx_buf_ctrl.md
Name: iob_eth_rx_buf_ctrl

Overview:
Multi-slot receive buffer controller for the Ethernet RX path, clocked entirely in RX_CLK.
- Sits between the byte-level receiver (frame start / byte write / CRC verdict) and a ring of NBUF frame buffers in one RX dual-port RAM.
- Allocates a slot per incoming frame, generates RAM write addresses, and commits or discards the frame on the CRC verdict.
- Releases slots when the host acknowledges via a toggle crossing from the system domain, so frames are not lost while the host drains the previous one.

Parameters:
NBUF, 4, number of frame slots; power of 2, >= 2
BUF_AW, 11, byte address width per slot (2048 bytes)
CNT_W, 8, width of the saturating drop/bad-frame counters

Ports:
RX_CLK  in  1  receive clock
rst  in  1  reset
rx_start  in  1  pulse: receiver detected SFD, frame begins
rx_wr  in  1  pulse: one frame byte valid this cycle
rx_end_ok  in  1  pulse: frame ended, CRC good
rx_end_bad  in  1  pulse: frame ended, CRC bad or MAC mismatch
ack_tgl  in  1  host release toggle, asynchronous (system domain)
wbuf_addr  out  log2(NBUF)+BUF_AW  RAM write address {wr_idx, byte_cnt}
wbuf_we  out  1  RAM write enable
rd_idx  out  log2(NBUF)  oldest committed slot
rd_len  out  BUF_AW  byte length of slot rd_idx
frame_cnt  out  log2(NBUF)+1  committed, unreleased frames
frames_avail  out  1  frame_cnt != 0
drop_cnt  out  CNT_W  frames dropped because no slot was free (saturating)
bad_cnt  out  CNT_W  frames discarded: bad CRC, overflow, or restart (saturating)

Behaviour:
- Reset is rst, asynchronous, active-high; clock is RX_CLK.
- Reset values: state=IDLE, wr_idx=0, rd_idx=0, byte_cnt=0, frame_cnt=0, all len[] =0, drop_cnt=0, bad_cnt=0, ack synchronizer flops=0. Outputs follow: wbuf_we=0, frames_avail=0, rd_len=0.
- Reset mid-frame discards the frame and all committed frames.
- Write path (combinational, zero latency):
  - wbuf_we = rx_wr && state==RECV.
  - wbuf_addr = {wr_idx, byte_cnt}.
  - byte_cnt increments on each accepted write.
- State machine IDLE / RECV / DROP:
  - IDLE, rx_start, frame_cnt<NBUF -> RECV; byte_cnt<=0.
  - IDLE, rx_start, frame_cnt==NBUF -> DROP; drop_cnt++.
  - IDLE: rx_wr, rx_end_ok and rx_end_bad are ignored.
  - RECV, rx_end_ok -> IDLE.
    - len[wr_idx] <= final byte count, including a write in the same cycle.
    - wr_idx++ (wraps modulo NBUF); frame_cnt++.
  - RECV, rx_end_ok with zero bytes: treated as bad (bad_cnt++, no commit).
  - RECV, rx_end_bad -> IDLE; no commit; bad_cnt++.
  - RECV, rx_wr while byte_cnt==2^BUF_AW-1:
    - The byte is written.
    - Next state DROP; bad_cnt++ (overflow).
    - The slot is not committed.
  - RECV, rx_start (receiver resynchronised): bad_cnt++; stay in RECV; byte_cnt<=0; same slot reused.
  - DROP, rx_end_ok or rx_end_bad -> IDLE, no counter change.
  - DROP, rx_start while a slot is free -> RECV with byte_cnt<=0.
  - DROP: rx_wr is ignored (wbuf_we=0).
  - rx_end_ok and rx_end_bad in the same cycle: bad wins.
- Host release:
  - ack_tgl passes through a 2-flop synchronizer plus one edge-detect flop.
  - Each detected edge (either polarity) is one release: if frame_cnt>0, rd_idx++ (wraps) and frame_cnt--.
  - A release with frame_cnt==0 is ignored.
  - Latency from ack_tgl change to frame_cnt update: 3 RX_CLK edges.
- Simultaneous commit and release: frame_cnt unchanged; wr_idx and rd_idx both advance.
- A release on a full ring frees a slot; an rx_start in the same cycle still sees frame_cnt==NBUF and drops.
- rd_len = len[rd_idx], registered-array read, valid whenever frames_avail=1.
- drop_cnt and bad_cnt saturate at 2^CNT_W-1 and clear only on reset.

Decomposition:
- Shared package/header (iob_eth_defs): state encodings ST_IDLE=0, ST_RECV=1, ST_DROP=2, and the default BUF_AW.
- One natural sub-module: iob_eth_tgl_sync.
  - Contents: 2-flop synchronizer plus edge detect, output a 1-cycle pulse.
  - Reuse: also usable for the TX-side handshake.
- Ring pointers, length array and FSM stay in the top module.

Test Plan:
- Good frame: rx_start, 64 rx_wr, rx_end_ok -> wbuf_addr 0x000..0x03F with wbuf_we each byte; frame_cnt=1, rd_idx=0, rd_len=64, frames_avail=1.
- Ring full/drop, NBUF=4:
  - Stimulus: commit 4 frames of 60 bytes, then a 5th frame.
  - Response: drop_cnt=1, no wbuf_we during the 5th frame.
  - Then: ack_tgl toggle -> after 3 clocks frame_cnt=3, rd_idx=1; the next frame is written at slot 0 (wbuf_addr=0x000).
- Bad CRC: rx_start, 100 bytes, rx_end_bad -> bad_cnt=1, frame_cnt unchanged, wr_idx unchanged; the next good frame reuses the same slot.
- Overflow, BUF_AW=4:
  - Stimulus: 20 rx_wr.
  - Response: 16 writes (0x0..0xF), then DROP; bad_cnt=1; a later rx_end_ok commits nothing.
- Simultaneous events:
  - rx_end_ok and a synchronized release pulse in the same cycle with frame_cnt=2 -> frame_cnt stays 2, both pointers advance.
  - rx_wr with rx_end_ok, 9 earlier bytes -> rd_len=10.
- Async reset asserted mid-RECV with frame_cnt=3 -> all outputs return to reset values immediately, wbuf_we=0; after release, the first frame lands at slot 0.
